// File: rtl/rrat.sv
// Retirement RAT: committed arch-reg -> PRF map and committed PRF free list.
// Retiring slots are folded in order each cycle; outputs are the registered result.
module rrat #(
    parameter int unsigned N                  = 4,
    parameter int unsigned RAT_SIZE           = 32,
    parameter int unsigned PRF_NUM_ENTRIES    = 64,
    parameter int unsigned REG_INDEX_BITS     = $clog2(RAT_SIZE),
    parameter int unsigned PRF_NUM_INDEX_BITS = $clog2(PRF_NUM_ENTRIES)
) (
    input  logic                                           clock,
    input  logic                                           reset,
    input  logic [N-1:0]                                   retire_valid,
    input  logic [N-1:0]                                   retire_dest_valid,
    input  logic [N-1:0][REG_INDEX_BITS-1:0]               retire_arch_dest,
    input  logic [N-1:0][PRF_NUM_INDEX_BITS-1:0]           retire_phys_dest,
    output logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0]    rrat_entries,
    output logic [PRF_NUM_ENTRIES-1:0]                     rrat_free_list,
    output logic [PRF_NUM_ENTRIES-1:0]                     free_vector_from_rrat,
    output logic [$clog2(N+1)-1:0]                         retired_count
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    logic [RAT_SIZE-1:0][PRF_NUM_INDEX_BITS-1:0] map_n;
    logic [PRF_NUM_ENTRIES-1:0]                  free_n;
    logic [PRF_NUM_ENTRIES-1:0]                  pulse_n;
    logic [CNT_W-1:0]                            count_n;
    logic [PRF_NUM_INDEX_BITS-1:0]               old_tag;

    // Running copy: older slots in the same cycle are forwarded to younger ones.
    always_comb begin
        map_n   = rrat_entries;
        free_n  = rrat_free_list;
        pulse_n = '0;
        count_n = '0;
        old_tag = '0;
        for (int unsigned n = 0; n < N; n++) begin
            count_n = count_n + CNT_W'(retire_valid[n]);
            if (retire_valid[n] && retire_dest_valid[n] && (retire_arch_dest[n] != '0)) begin
                old_tag                          = map_n[retire_arch_dest[n]];
                map_n[retire_arch_dest[n]]       = retire_phys_dest[n];
                free_n[retire_phys_dest[n]]      = 1'b0;
                // PRF 0 is the shared reset mapping and is never released.
                if ((old_tag != '0) && (old_tag != retire_phys_dest[n])) begin
                    free_n[old_tag]  = 1'b1;
                    pulse_n[old_tag] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rrat_entries          <= '0;
            rrat_free_list        <= '1;
            free_vector_from_rrat <= '0;
            retired_count         <= '0;
        end else begin
            rrat_entries          <= map_n;
            rrat_free_list        <= free_n;
            free_vector_from_rrat <= pulse_n;
            retired_count         <= count_n;
        end
    end

endmodule

// File: doc/rrat.md
# rrat

Retirement RAT: holds the architectural (committed) arch-reg → PRF mapping and the committed PRF free list. It sits at the commit end of the rename path and consumes up to `N` retiring instructions per cycle from the ROB. It produces three things for the rename RAT:
- `rrat_entries`, the committed map snapshot.
- `rrat_free_list`, the committed free list; the RAT restores both on `nuke`.
- `free_vector_from_rrat`, a one-cycle pulse of PRF entries released by retirement.

## Interface
Parameters:
- `N`, `` `N ``: retire width in instructions per cycle.
- `RAT_SIZE`, `` `RAT_SIZE ``: number of architectural registers (32).
- `PRF_NUM_ENTRIES`, `` `PRF_NUM_ENTRIES ``: number of physical registers.
- `REG_INDEX_BITS` / `PRF_NUM_INDEX_BITS`: log2 of the two sizes above.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `retire_valid`  in  [N]  slot n retires this cycle; slot 0 is oldest.
- `retire_dest_valid`  in  [N]  slot n writes a destination register.
- `retire_arch_dest`  in  [N][REG_INDEX_BITS]  architectural destination.
- `retire_phys_dest`  in  [N][PRF_NUM_INDEX_BITS]  PRF tag assigned at rename.
- `rrat_entries`  out  [RAT_SIZE][PRF_NUM_INDEX_BITS]  registered committed map.
- `rrat_free_list`  out  [PRF_NUM_ENTRIES]  registered committed free list; 1 = free.
- `free_vector_from_rrat`  out  [PRF_NUM_ENTRIES]  registered pulse; bit p = 1 means PRF p was released by the previous cycle's retirement.
- `retired_count`  out  [$clog2(N+1)]  registered count of slots retired in the previous cycle (perf/debug).

## Operation
- Slot n is effective iff `retire_valid[n] && retire_dest_valid[n] && retire_arch_dest[n] != 0`. Non-effective slots change no state and free nothing.
- Process effective slots in order 0..N-1 against a running copy of the map and free list:
  - `old` = running map[arch_dest]. This includes updates from earlier slots in the same cycle, so older same-cycle writers are forwarded.
  - Running map[arch_dest] = phys_dest.
  - Running free[phys_dest] = 0.
  - If `old != 0` and `old != phys_dest`: running free[old] = 1 and next_free_vector[old] = 1.
- Same arch reg written by slots i < j in one cycle: the final map holds slot j's tag. Slot i's tag is released (free = 1, pulsed). The pre-cycle mapping is released once, by slot i.
- When a later slot's clear and an earlier slot's set hit the same PRF bit, the later slot wins. This only occurs on malformed input.
- PRF 0 is the shared reset mapping. It is never pulsed in `free_vector_from_rrat` and never set free by retirement.
- Retirement bypasses nothing to the outputs. All outputs are flops loaded with the running copies at posedge.
- `retired_count` = number of slots with `retire_valid` set, regardless of dest validity.
- The block has no `nuke` input. It holds committed state only and is unaffected by flushes.

## Timing
- Reset (async assert, takes effect immediately): `rrat_entries` = all 0; `rrat_free_list` = all 1 (matches the RAT reset value); `free_vector_from_rrat` = 0; `retired_count` = 0.
- Reset deassertion is synchronised externally. The first update occurs on the first posedge with `reset` low.
- Latency: retirement presented in cycle t is visible on `rrat_entries` / `rrat_free_list` / `free_vector_from_rrat` in cycle t+1.
- `free_vector_from_rrat` is high for exactly one cycle per release. It is 0 in any cycle following a cycle with no effective release.
- Contract with the ROB: `nuke` is asserted no earlier than the cycle after the last instruction to be kept retires. The RAT therefore copies an `rrat_entries` / `rrat_free_list` that already includes it.
- Because `free_vector_from_rrat` is already folded into `rrat_free_list`, its pulse may be dropped by the RAT in a nuke cycle without loss.
- Asserting `reset` mid-retirement discards the in-flight update; no partial writes.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle → outputs go to map all 0, free all 1, pulse 0 before the next edge.
- Single retire: slot0 retires arch 5 → PRF 12 (prior map 5 → 7) → next cycle map[5] = 12, free[12] = 0, free[7] = 1, pulse exactly bit 7, then pulse returns to 0.
- Same-cycle collision (N ≥ 2): map[3] = 9; slot0 retires 3 → 20 and slot1 retires 3 → 21 → map[3] = 21, free[20] = free[9] = 1, free[21] = 0, pulse bits {9, 20}.
- Ignored slots: arch 0 → PRF 30, `retire_dest_valid` = 0, and `retire_valid` = 0 slots → map, free list, and pulse unchanged; `retired_count` counts only `retire_valid` slots.
- PRF 0 rule: first retire after reset, arch 4 → PRF 15 → map[4] = 15, free[15] = 0, pulse all 0.
- Full-width stream: N distinct arch regs retiring every cycle for 200 random cycles → compare against a reference model each cycle. Free-list popcount + number of distinct mapped nonzero tags stays consistent.
